regfile_mp_init: RTL

Parametrised successor to the single-cycle CPU register file. It has two write ports and two read ports, with write-through forwarding from both write ports to both read ports. A sequential init engine walks the array after reset or on request, instead of resetting all entries in one cycle. A per-register pending scoreboard lets a multi-cycle or pipelined datapath detect RAW hazards. It sits between decode and writeback in the next-generation datapath.

---
 rtl/regfile_mp_init.sv | 121 ++++++++++++
 1 files changed

// File: rtl/regfile_mp_init.sv
// Dual-write, dual-read register file with write-through forwarding, a sequential
// init engine and a per-register pending scoreboard for RAW hazard detection.
module regfile_mp_init #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned INIT_MODE = 1,
  parameter int unsigned ZERO_REG  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  output logic              busy,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic [ADDR_W-1:0] rd0_addr,
  output logic [DATA_W-1:0] rd0_data,
  output logic              rd0_pend,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  output logic              rd1_pend,
  input  logic              pend_en,
  input  logic [ADDR_W-1:0] pend_addr
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic run;
  logic wr0_ok, wr1_ok, pend_ok;

  assign run  = (state_q == StRun);
  assign busy = ~run;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wr0_ok  = run && wr0_en && !is_zero_reg(wr0_addr);
  assign wr1_ok  = run && wr1_en && !is_zero_reg(wr1_addr);
  assign pend_ok = run && pend_en && !is_zero_reg(pend_addr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    mem_d   = mem_q;
    if (!run) begin
      mem_d[cnt_q] = (INIT_MODE != 0) ? DATA_W'(cnt_q) : '0;
      cnt_d        = cnt_q + ADDR_W'(1);
      if (cnt_q == {ADDR_W{1'b1}}) begin
        state_d = StRun;
      end
    end else begin
      // wr1 is applied last so it wins a same-address collision
      if (wr0_ok) mem_d[wr0_addr] = wr0_data;
      if (wr1_ok) mem_d[wr1_addr] = wr1_data;
      if (wr0_en) pend_d[wr0_addr] = 1'b0;
      if (wr1_en) pend_d[wr1_addr] = 1'b0;
      if (pend_ok) pend_d[pend_addr] = 1'b1;
      if (init_req) begin
        state_d = StInit;
        cnt_d   = '0;
        pend_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StInit;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Array contents are undefined until init completes, so no reset here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  function automatic logic [DATA_W-1:0] rd_fwd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] r;
    r = mem_q[a];
    if (wr0_ok && (wr0_addr == a)) r = wr0_data;
    if (wr1_ok && (wr1_addr == a)) r = wr1_data;
    if (!run || is_zero_reg(a)) r = '0;
    return r;
  endfunction

  // A write hitting the register this cycle hides its pending bit unless it is re-issued.
  function automatic logic rd_pnd(input logic [ADDR_W-1:0] a);
    logic hit, tgt;
    hit = (wr0_en && (wr0_addr == a)) || (wr1_en && (wr1_addr == a));
    tgt = pend_en && (pend_addr == a);
    return run && pend_q[a] && !(hit && !tgt);
  endfunction

  always_comb begin
    rd0_data = rd_fwd(rd0_addr);
    rd1_data = rd_fwd(rd1_addr);
    rd0_pend = rd_pnd(rd0_addr);
    rd1_pend = rd_pnd(rd1_addr);
  end

endmodule
